// File: rtl/sram_mw.sv
// sram_mw: synchronous 1R1W buffer SRAM for the matrix co-accelerator.
// Per-byte write mask, selectable read-during-write behaviour, a one-slot
// valid/ready read response with output hold, and a post-reset zero-fill.
module sram_mw #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned RDW_NEW    = 0,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data
);

  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  // Storage array; no reset so that rst leaves contents alone.
  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  logic                    wr_fire;
  logic                    rd_fire;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NumBytes-1:0]     mem_wbe;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Handshake readiness: nothing is accepted while the zero-fill runs.
  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    if (state_q == StRun) begin
      wr_ready = 1'b1;
      // Single output slot: accept a read when the slot is empty or draining.
      rd_ready = !rsp_valid_q || rsp_ready;
    end
  end

  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign init_busy = (state_q == StInit);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Fill sequencer next state: one word per cycle, leave after word Depth-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(Depth - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Write port mux: the fill sequencer owns the port during init.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_wbe   = wr_be;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (wr_fire) begin
      mem_we    = 1'b1;
    end
  end

  // Read word, optionally forwarding same-cycle write bytes to the same address.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if ((RDW_NEW != 0) && wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  // Response slot: load on an accepted read, hold under backpressure, drop on pop.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rd_word;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (INIT_ZERO != 0) ? StInit : StRun;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Byte-masked array write; suppressed during rst so reset never touches data.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (mem_wbe[i]) begin
          mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Simulation backdoor: overwrite a full word, bypassing the handshakes.
  task automatic load_mem(input logic [ADDR_WIDTH-1:0] index,
                          input logic [DATA_WIDTH-1:0] data);
    mem_q[index] <= data;
  endtask

endmodule

// File: tb/tb_sram_mw.sv
// tb_sram_mw: directed bench for sram_mw with a queue-based response scoreboard.
// Two instances share all inputs; u_dut0 returns old data on a same-address
// read/write collision, u_dut1 returns the byte-merged new data.
module tb_sram_mw;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 6;
  localparam int unsigned NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rsp_ready;

  logic          init_busy0, wr_ready0, rd_ready0, rsp_valid0;
  logic [DW-1:0] rsp_data0;
  logic          init_busy1, wr_ready1, rd_ready1, rsp_valid1;
  logic [DW-1:0] rsp_data1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];

  always #5 clk = ~clk;

  sram_mw #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RDW_NEW   (0),
    .INIT_ZERO (1)
  ) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy0),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready0),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready0),
    .rd_addr  (rd_addr),
    .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data0)
  );

  sram_mw #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RDW_NEW   (1),
    .INIT_ZERO (1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy1),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready1),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready1),
    .rd_addr  (rd_addr),
    .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data1)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: pop and compare whenever a response is consumed.
  always @(negedge clk) begin
    if (rsp_valid0 && rsp_ready) begin
      if (exp0_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp0_unexpected: got %h want no response", rsp_data0);
      end else begin
        check("rsp0", rsp_data0, exp0_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid1 && rsp_ready) begin
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp1_unexpected: got %h want no response", rsp_data1);
      end else begin
        check("rsp1", rsp_data1, exp1_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_both(input logic [AW-1:0] a, input logic [DW-1:0] d);
    u_dut0.load_mem(a, d);
    u_dut1.load_mem(a, d);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    step();
    wr_valid = 1'b0;
  endtask

  // Issue a read, push expectations once the handshake is seen (bounded wait).
  task automatic read_accept(input logic [AW-1:0] a, input logic [DW-1:0] e0,
                             input logic [DW-1:0] e1);
    bit got;
    got      = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = a;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rd_ready0) begin
        exp0_q.push_back(e0);
        exp1_q.push_back(e1);
        got = 1'b1;
      end
      step();
    end
    rd_valid = 1'b0;
    check_int("rd_accept", int'(got), 1);
  endtask

  // Count zero-fill cycles and any handshake readiness seen while filling.
  task automatic count_init(input string nm);
    int n;
    int viol;
    n    = 0;
    viol = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!init_busy0) break;
      n++;
      if (wr_ready0 || rd_ready0 || wr_ready1 || rd_ready1) viol++;
    end
    check_int({nm, "_cycles"}, n, 64);
    check_int({nm, "_ready_low"}, viol, 0);
  endtask

  initial begin
    int            tp;
    int            miss;
    logic [7:0]    b;

    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_be     = '0;
    rd_valid  = 1'b0;
    rd_addr   = '0;
    rsp_ready = 1'b1;

    // Preload all ones so the zero-fill is observable.
    for (int i = 0; i < 64; i++) load_both(AW'(i), '1);

    @(negedge clk);
    check_int("rst_rsp_valid", int'(rsp_valid0), 0);
    check("rst_rsp_data", rsp_data0, '0);
    check_int("rst_init_busy", int'(init_busy0), 1);
    check_int("rst_wr_ready", int'(wr_ready0), 0);
    step();
    rst = 1'b0;

    // Requests during fill must be ignored (write to word 0 would survive).
    wr_valid = 1'b1;
    wr_addr  = '0;
    wr_data  = {NB{8'h77}};
    wr_be    = '1;
    rd_valid = 1'b1;
    rd_addr  = 6'd63;
    count_init("init1");
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    step();
    read_accept(6'd0, '0, '0);
    read_accept(6'd63, '0, '0);

    // Byte mask.
    do_write(6'd5, '1, '1);
    do_write(6'd5, '0, 64'h1);
    read_accept(6'd5, {{63{8'hFF}}, 8'h00}, {{63{8'hFF}}, 8'h00});

    // Zero byte enable is a handshaking no-op.
    load_both(6'd12, 512'hCAFE);
    do_write(6'd12, '0, '0);
    read_accept(6'd12, 512'hCAFE, 512'hCAFE);
    step();

    // Backpressure: held response survives later writes to the same word.
    load_both(6'd3, 512'hA5);
    rsp_ready = 1'b0;
    read_accept(6'd3, 512'hA5, 512'hA5);
    rd_valid = 1'b1;
    rd_addr  = 6'd4;
    wr_valid = 1'b1;
    wr_addr  = 6'd3;
    wr_data  = 512'h5A;
    wr_be    = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_int("hold_valid", int'(rsp_valid0), 1);
      check("hold_data", rsp_data0, 512'hA5);
      check_int("hold_rd_ready", int'(rd_ready0), 0);
      step();
    end
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check_int("pop_valid_drop", int'(rsp_valid0), 0);
    step();
    read_accept(6'd3, 512'h5A, 512'h5A);
    step();

    // Throughput: back-to-back reads, one response per cycle.
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      load_both(AW'(i), {NB{b}});
    end
    tp       = 0;
    miss     = 0;
    rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b       = 8'h10 + 8'(i);
      rd_addr = AW'(i);
      @(negedge clk);
      if (rd_ready0) begin
        exp0_q.push_back({NB{b}});
        exp1_q.push_back({NB{b}});
      end else begin
        miss++;
      end
      if (rsp_valid0) tp++;
      step();
    end
    rd_valid = 1'b0;
    @(negedge clk);
    if (rsp_valid0) tp++;
    check_int("tp_rd_ready_miss", miss, 0);
    check_int("tp_valid_cycles", tp, 8);
    step();
    @(negedge clk);
    check_int("tp_valid_after", int'(rsp_valid0), 0);
    step();

    // Read-during-write to the same address.
    load_both(6'd9, 512'h3344);
    wr_valid = 1'b1;
    wr_addr  = 6'd9;
    wr_data  = 512'h1122;
    wr_be    = 64'h1;
    read_accept(6'd9, 512'h3344, 512'h3322);
    wr_valid = 1'b0;
    read_accept(6'd9, 512'h3322, 512'h3322);

    // Different addresses in the same cycle do not interact.
    load_both(6'd10, 512'hAAAA);
    load_both(6'd11, 512'hBBBB);
    wr_valid = 1'b1;
    wr_addr  = 6'd10;
    wr_data  = 512'h1234;
    wr_be    = '1;
    read_accept(6'd11, 512'hBBBB, 512'hBBBB);
    wr_valid = 1'b0;
    read_accept(6'd10, 512'h1234, 512'h1234);
    step();

    // Reset while a response is held: it is dropped, fill restarts.
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = 6'd10;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    check_int("prerst_hold_valid", int'(rsp_valid0), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_int("midrst_rsp_valid0", int'(rsp_valid0), 0);
    check_int("midrst_rsp_valid1", int'(rsp_valid1), 0);
    check_int("midrst_init_busy", int'(init_busy0), 1);
    rsp_ready = 1'b1;

    // Abort the fill at count 20 and require a complete refill.
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    load_both(6'd2, '1);
    load_both(6'd40, '1);
    step();
    rst = 1'b0;
    count_init("init2");
    step();
    read_accept(6'd2, '0, '0);
    read_accept(6'd40, '0, '0);
    read_accept(6'd25, '0, '0);

    step();
    step();
    check_int("q0_drained", exp0_q.size(), 0);
    check_int("q1_drained", exp1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_mw.md
Name: sram_mw

Overview:
- Next-generation synchronous 1R1W SRAM model for the matrix co-accelerator buffers.
- Generalises the plain SRAM with:
  - a per-byte write mask,
  - a selectable read-during-write mode,
  - a valid/ready read path with output hold,
  - a post-reset hardware zero-fill sequencer.
- Sits between the controller/DMA and the PE array as the operand/result buffer.

Parameters:
- DATA_WIDTH, 512, bits per word; must be a multiple of 8.
- ADDR_WIDTH, 6, address bits; DEPTH = 2^ADDR_WIDTH.
- RDW_NEW, 0, same-cycle read/write to the same address: 0 returns old data, 1 returns new data merged per byte.
- INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = skip fill.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the zero-fill sequence runs.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid && rd_ready.
- rd_addr  in  ADDR_WIDTH  read address.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_WIDTH  read data; stable while rsp_valid && !rsp_ready.

Behaviour:
- Reset (rst high at a posedge):
  - rsp_valid=0, rsp_data=0, init counter=0.
  - State = INIT if INIT_ZERO, else RUN.
  - init_busy=1 in INIT, 0 otherwise.
  - Memory contents are untouched by rst itself.
- FSM states are INIT and RUN.
- INIT:
  - Writes zero to word[cnt] each cycle and increments cnt.
  - After writing word DEPTH-1, moves to RUN on the next cycle. INIT lasts exactly DEPTH cycles.
  - wr_ready=0 and rd_ready=0 throughout INIT; requests are ignored, not queued.
- RUN:
  - wr_ready=1 always.
  - rd_ready = !rsp_valid || rsp_ready (single output slot, full-throughput pass-through).
- Write:
  - On an accepted write, for each i with wr_be[i]=1, byte i of mem[wr_addr] takes wr_data byte i. Other bytes are unchanged.
  - wr_be=0 is a legal no-op that still handshakes.
- Read latency:
  - An accepted read at edge N gives rsp_valid=1 and rsp_data=mem[rd_addr] after edge N.
  - That is one-cycle latency.
- Response hold:
  - rsp_valid && !rsp_ready: rsp_data and rsp_valid hold, rd_ready=0.
  - Later writes to that address do not alter the held rsp_data.
- Response pop:
  - rsp_valid && rsp_ready with no new accepted read: rsp_valid drops to 0 at the next edge.
  - With a new accepted read in the same cycle, rsp_valid stays 1 and rsp_data is replaced.
- Read and write accepted in the same cycle to the same address:
  - RDW_NEW=0: response carries the pre-write word.
  - RDW_NEW=1: response carries old bytes where wr_be=0 and new bytes where wr_be=1.
  - Different addresses: independent, no interaction.
- Write then read of the same address on the next cycle returns the written data in both modes.
- rst asserted mid-INIT or mid-response:
  - Aborts and restarts per the reset rules.
  - A pending response is dropped (rsp_valid=0).
  - Partially zero-filled memory is refilled from word 0.
- Address wrap: none. Addresses are exact within DEPTH.
- Simulation-only task load_mem(index, data) writes a full word directly, bypassing handshakes.

Test Plan:
- Init fill (INIT_ZERO=1, ADDR_WIDTH=6): preload all words 0xFF..FF, pulse rst → init_busy high for exactly 64 cycles with rd_ready/wr_ready=0; then read addr 0 and 63 → rsp_data=0.
- Byte mask: write addr 5 all-ones with be=all, then write data 0 with be=0x…0001 → read addr 5 gives all-ones except byte 0 = 0x00.
- Backpressure: read addr 3 (preloaded 0xA5) with rsp_ready=0 for 4 cycles while writing addr 3 = 0x5A → rsp_data stays 0xA5, rd_ready=0; release → a single response is consumed.
- Throughput: rsp_ready=1, rd_valid every cycle for addrs 0..7 → rsp_valid continuous for 8 cycles with data in order, 1-cycle latency.
- RDW: same-cycle write 0x1122 (be lower byte only) and read of addr 9 holding 0x3344 → RDW_NEW=0 returns 0x3344; RDW_NEW=1 returns 0x3322.
- Mid-operation reset: assert rst during INIT at cnt=20 and while a response is held → rsp_valid=0 next cycle and the fill restarts at cnt=0 (a full 64-cycle init_busy).
